// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result valid-ready bundle between the EX-stage operand muxes, the ALU and the EX/MEM register.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       aluc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;
   logic             zero;
   logic             carry;
   logic             ovf;
   modport master (
      output in_valid, a, b, aluc, out_ready,
      input  in_ready, out_valid, r, zero, carry, ovf
   );
   modport slave (
      input  in_valid, a, b, aluc, out_ready,
      output in_ready, out_valid, r, zero, carry, ovf
   );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with flags, valid/ready handshake and an iterative shift-add multiply.
module seq_alu #(
   parameter int WIDTH  = 32,
   parameter int SHW    = $clog2(WIDTH),
   parameter int MUL_EN = 1
) (
   input logic      clk,
   input logic      rst,
   seq_alu_if.slave bus
);
   typedef enum logic {IDLE, MUL} state_t;
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
   state_t           state_q;
   logic             out_valid_q, zero_q, carry_q, ovf_q;
   logic [WIDTH-1:0] r_q, acc_q, mcand_q, mplier_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] res_d, acc_d;
   logic             carry_d, ovf_d;
   logic [WIDTH:0]   sum, diff;
   logic [SHW-1:0]   sh;
   logic             accept, is_mul;
   assign sh     = bus.b[SHW-1:0];
   assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff   = {1'b0, bus.a} - {1'b0, bus.b};
   assign is_mul = (MUL_EN != 0) && (bus.aluc == 4'b1000);
   assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.r         = r_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.ovf       = ovf_q;
   always_comb begin
      res_d   = bus.a ^ bus.b;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (bus.aluc)
         4'b0010: begin
            res_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         // a - b in WIDTH+1 bits borrows exactly when a + ~b + 1 produces no carry
         4'b0110: begin
            res_d   = diff[WIDTH-1:0];
            carry_d = !diff[WIDTH];
            ovf_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'b0001: res_d = bus.a | bus.b;
         4'b0000: res_d = bus.a & bus.b;
         4'b0011: res_d = bus.a << sh;
         4'b0100: res_d = bus.a >> sh;
         4'b0101: res_d = $signed(bus.a) >>> sh;
         4'b0111: res_d = WIDTH'($signed(bus.a) < $signed(bus.b));
         4'b1001: res_d = WIDTH'(bus.a < bus.b);
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         r_q         <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else if (state_q == MUL) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + SHW'(1);
         if (cnt_q == LAST) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            r_q         <= acc_d;
            zero_q      <= acc_d == '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
         end
      end else if (accept && is_mul) begin
         state_q     <= MUL;
         out_valid_q <= 1'b0;
         mcand_q     <= bus.a;
         mplier_q    <= bus.b;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         r_q         <= res_d;
         zero_q      <= res_d == '0;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table for single-cycle ops plus hand sequences for multiply, backpressure and reset.
module tb_seq_alu;
   localparam int W = 32;
   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b, r;
      logic         z, c, v;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   int   stale;
   vec_t tbl [18];
   seq_alu_if #(.WIDTH(W)) bus ();
   seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.in_valid = v;
      bus.aluc     = op;
      bus.a        = a;
      bus.b        = b;
   endtask
   task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
      int rise = 0;
      int busy = 0;
      @(negedge clk);
      drive(1'b1, 4'b1000, a, b);
      bus.out_ready = 1'b1;
      #1;
      chk("mul_accept_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      drive(1'b0, 4'b0010, '0, '0);
      for (int n = 1; n <= 40 && rise == 0; n++) begin
         if (bus.out_valid) rise = n;
         else if (!bus.in_ready) busy++;
         if (rise == 0) @(negedge clk);
      end
      chk("mul_latency", 64'(rise), 64'd33);
      chk("mul_busy_cycles", 64'(busy), 64'd32);
      chk("mul_result", {29'b0, bus.zero, bus.carry, bus.ovf, bus.r}, {29'b0, exp == '0, 2'b00, exp});
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1);
   end
   initial begin
      tbl[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b1, 1'b0};
      tbl[1]  = '{4'b0110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
      tbl[2]  = '{4'b0101, 32'hF0000000, 32'h4,        32'hFF000000, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{4'b0100, 32'hF0000000, 32'h4,        32'h0F000000, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{4'b0111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'b1001, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1'b0};
      tbl[6]  = '{4'b1111, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{4'b0001, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, 1'b0};
      tbl[8]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{4'b0011, 32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{4'b0011, 32'hABCD,     32'h20,       32'hABCD,     1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'b0010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{4'b0110, 32'h5,        32'h5,        32'h0,        1'b1, 1'b1, 1'b0};
      tbl[13] = '{4'b0110, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{4'b0111, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1'b0};
      tbl[15] = '{4'b1001, 32'h1,        32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 1'b0};
      tbl[16] = '{4'b0101, 32'h80000000, 32'h0,        32'h80000000, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{4'b0100, 32'h80000000, 32'd31,       32'h1,        1'b0, 1'b0, 1'b0};
      drive(1'b0, 4'b0000, '0, '0);
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_state", {27'b0, bus.out_valid, bus.zero, bus.carry, bus.ovf, bus.in_ready, bus.r}, 64'h1_0000_0000);
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
         @(negedge clk);
         chk($sformatf("vec%0d_op%b", i, tbl[i].op), {28'b0, bus.out_valid, bus.zero, bus.carry, bus.ovf, bus.r},
             {28'b0, 1'b1, tbl[i].z, tbl[i].c, tbl[i].v, tbl[i].r});
      end
      drive(1'b0, 4'b0000, '0, '0);
      mul_run(32'd1234, 32'd5678, 32'd7006652);
      mul_run(32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(1'b1, 4'b0001, 32'hF0, 32'h0F);
      @(negedge clk);
      drive(1'b1, 4'b0010, 32'h1, 32'h2);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold%0d", i), {30'b0, bus.out_valid, bus.in_ready, bus.r}, {30'b0, 1'b1, 1'b0, 32'hFF});
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("release_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      chk("second_op", {28'b0, bus.out_valid, bus.zero, bus.carry, bus.ovf, bus.r}, {28'b0, 4'b1000, 32'h3});
      drive(1'b0, 4'b0000, '0, '0);
      @(negedge clk);
      chk("drain", 64'(bus.out_valid), 64'd0);
      drive(1'b1, 4'b1000, 32'd3, 32'd5);
      @(negedge clk);
      drive(1'b0, 4'b0000, '0, '0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_mul_reset", {30'b0, bus.out_valid, bus.in_ready, bus.r}, {30'b0, 1'b0, 1'b1, 32'h0});
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("no_stale_result", 64'(stale), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
